l1_data_mem_responder: RTL and testbench
========================================

L1_DATA_MEM_RESPONDER -- requirements
Module: l1_data_mem_responder

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-002 P_DEPTH, 4, request FIFO depth (power of two, >=2).
REQ-003 iCLOCK  in  1  clock.
REQ-004 iRESET_SYNC  in  1  synchronous active-high reset.
REQ-005 iREMOVE  in  1  drop queued requests and suppress in-flight response.
REQ-006 iDATA_REQ  in  1  cache request strobe.
REQ-007 oDATA_LOCK  out  1  request FIFO full; cache holds its request.
REQ-008 iDATA_ORDER  in  2  access size: 0=byte, 1=half, 2=word.
REQ-009 iDATA_MASK  in  4  byte enables within the 32-bit word.
REQ-010 iDATA_RW  in  1  0=read, 1=write.
REQ-011 iDATA_TID  in  14  task id.
REQ-012 iDATA_MMUMOD  in  2  MMU mode.
REQ-013 iDATA_MMUPS  in  3  MMU page size.
REQ-014 iDATA_PDT  in  32  page directory table base.
REQ-015 iDATA_ADDR  in  32  byte address.
REQ-016 iDATA_DATA  in  32  write data.
REQ-017 oDATA_VALID  out  1  one-cycle response pulse.
REQ-018 oDATA_MMU_FLAGS  out  24  {hi-word flags[23:12], lo-word flags[11:0]}.
REQ-019 oDATA_DATA  out  64  read doubleword; 0 on write response.
REQ-020 oMEM_REQ  out  1  memory request, held until accepted.
REQ-021 iMEM_BUSY  in  1  memory not accepting; transfer occurs when oMEM_REQ && !iMEM_BUSY.
REQ-022 oMEM_RW  out  1  0=read, 1=write.
REQ-023 oMEM_MASK  out  8  doubleword byte enables.
REQ-024 oMEM_CTRL  out  51  {TID, MMUMOD, MMUPS, PDT} of the issued entry.
REQ-025 oMEM_ADDR  out  32  {ADDR[31:3], 3'b000}.
REQ-026 oMEM_DATA  out  64  lane-placed write data.
REQ-027 iMEM_VALID  in  1  memory completion strobe.
REQ-028 iMEM_MMU_FLAGS  in  24  flags for the completed doubleword.
REQ-029 iMEM_DATA  in  64  read data.

Function
REQ-030 Push when iDATA_REQ && !oDATA_LOCK; oDATA_LOCK SHALL equal (count==P_DEPTH), driven from registered count only; push and pop in the same cycle SHALL leave count unchanged, including when full; read and write pointers SHALL wrap modulo P_DEPTH.
REQ-031 FSM states: IDLE, ISSUE, WAIT, RESP. IDLE->ISSUE when FIFO is non-empty; ISSUE->WAIT and pop on transfer; WAIT->RESP on iMEM_VALID; RESP->ISSUE if FIFO is non-empty, else RESP->IDLE.
REQ-032 oMEM_REQ SHALL be 1 only in ISSUE, and oMEM_* SHALL be driven from the FIFO head. A request pushed into an empty FIFO with the FSM in IDLE at edge N SHALL raise oMEM_REQ in cycle N+1.
REQ-033 Lane placement: ADDR[2]=0 -> mask {4'h0, MASK}, data {32'h0, DATA}; ADDR[2]=1 -> mask {MASK, 4'h0}, data {DATA, 32'h0}. For reads, oMEM_MASK SHALL be 8'hFF.
REQ-034 iMEM_DATA and iMEM_MMU_FLAGS SHALL be registered on iMEM_VALID in WAIT. oDATA_VALID SHALL pulse for exactly one cycle in RESP, one cycle after iMEM_VALID. Write responses SHALL carry oDATA_DATA=0 and the returned flags.
REQ-035 Responses SHALL return in request order, with exactly one outstanding memory transaction; iMEM_VALID outside WAIT SHALL be ignored.
REQ-036 iREMOVE SHALL clear the FIFO in the same edge and take priority over a simultaneous push. An in-flight transaction SHALL complete on the memory side with oDATA_VALID suppressed (RESP skipped).

Reset
REQ-037 On iRESET_SYNC: FIFO empty; FSM in IDLE; all outputs 0 (oDATA_LOCK 0, oDATA_VALID 0, oDATA_DATA 0, oDATA_MMU_FLAGS 0). Reset mid-transaction SHALL abandon it, and a later iMEM_VALID SHALL be ignored.

Structure
REQ-038 RW and ORDER encodings SHALL be defined in common.h; FSM state constants SHALL be local to the module.
REQ-039 The FIFO SHALL be a sub-module, l1_data_mem_req_fifo (122-bit entry, P_DEPTH deep, push/pop/flush, count/full/empty outputs).

Verification
REQ-040 Read ADDR=0x0000_1004, iMEM_DATA=0x1111_2222_3333_4444, zero busy -> oMEM_ADDR=0x1000, oMEM_MASK=0xFF; oDATA_VALID one cycle after iMEM_VALID, oDATA_DATA=0x1111_2222_3333_4444.
REQ-041 Write ADDR=0x24, MASK=4'h3, DATA=0xAABB_CCDD -> oMEM_MASK=0x30, oMEM_DATA=0xAABB_CCDD_0000_0000; response has oDATA_DATA=0.
REQ-042 iMEM_BUSY held high, 5 back-to-back pushes with P_DEPTH=4 -> oDATA_LOCK=1 after the 4th push; 5th held; later responses in push order.
REQ-043 FIFO full, pop and push in the same cycle -> count stays 4; oDATA_LOCK stays 1.
REQ-044 iREMOVE in WAIT with 2 queued -> FIFO empty; iMEM_VALID produces no oDATA_VALID; FSM returns to IDLE.
REQ-045 iRESET_SYNC in WAIT, then iMEM_VALID -> no oDATA_VALID, all outputs 0.

Source files
------------

// File: rtl/l1_data_mem_responder_pkg.sv
// Shared types for the L1 data-side memory responder.
// Request entry layout and lane placement helpers.
package l1_data_mem_responder_pkg;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'd0,
    ORDER_HALF = 2'd1,
    ORDER_WORD = 2'd2
  } order_e;

  // 122-bit queued request
  typedef struct packed {
    order_e      order;
    logic [3:0]  mask;
    rw_e         rw;
    logic [13:0] tid;
    logic [1:0]  mmumod;
    logic [2:0]  mmups;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  function automatic logic [7:0] lane_mask(
    input req_t r
  );
    if (r.rw == RW_READ) return 8'hFF;
    return r.addr[2] ? {r.mask, 4'h0}
                     : {4'h0, r.mask};
  endfunction

  function automatic logic [63:0] lane_data(
    input req_t r
  );
    if (r.rw == RW_READ) return 64'h0;
    return r.addr[2] ? {r.data, 32'h0}
                     : {32'h0, r.data};
  endfunction

endpackage

// File: rtl/l1_data_mem_responder_if.sv
// Cache-side and memory-side bus of the responder.
// slave: responder view; master: cache/memory view.
interface l1_data_mem_responder_if;
  logic        iREMOVE;
  logic        iDATA_REQ;
  logic        oDATA_LOCK;
  logic [1:0]  iDATA_ORDER;
  logic [3:0]  iDATA_MASK;
  logic        iDATA_RW;
  logic [13:0] iDATA_TID;
  logic [1:0]  iDATA_MMUMOD;
  logic [2:0]  iDATA_MMUPS;
  logic [31:0] iDATA_PDT;
  logic [31:0] iDATA_ADDR;
  logic [31:0] iDATA_DATA;
  logic        oDATA_VALID;
  logic [23:0] oDATA_MMU_FLAGS;
  logic [63:0] oDATA_DATA;
  logic        oMEM_REQ;
  logic        iMEM_BUSY;
  logic        oMEM_RW;
  logic [7:0]  oMEM_MASK;
  logic [50:0] oMEM_CTRL;
  logic [31:0] oMEM_ADDR;
  logic [63:0] oMEM_DATA;
  logic        iMEM_VALID;
  logic [23:0] iMEM_MMU_FLAGS;
  logic [63:0] iMEM_DATA;

  modport slave (
    input  iREMOVE, iDATA_REQ, iDATA_ORDER,
    input  iDATA_MASK, iDATA_RW, iDATA_TID,
    input  iDATA_MMUMOD, iDATA_MMUPS,
    input  iDATA_PDT, iDATA_ADDR, iDATA_DATA,
    input  iMEM_BUSY, iMEM_VALID,
    input  iMEM_MMU_FLAGS, iMEM_DATA,
    output oDATA_LOCK, oDATA_VALID,
    output oDATA_MMU_FLAGS, oDATA_DATA,
    output oMEM_REQ, oMEM_RW, oMEM_MASK,
    output oMEM_CTRL, oMEM_ADDR, oMEM_DATA
  );

  modport master (
    output iREMOVE, iDATA_REQ, iDATA_ORDER,
    output iDATA_MASK, iDATA_RW, iDATA_TID,
    output iDATA_MMUMOD, iDATA_MMUPS,
    output iDATA_PDT, iDATA_ADDR, iDATA_DATA,
    output iMEM_BUSY, iMEM_VALID,
    output iMEM_MMU_FLAGS, iMEM_DATA,
    input  oDATA_LOCK, oDATA_VALID,
    input  oDATA_MMU_FLAGS, oDATA_DATA,
    input  oMEM_REQ, oMEM_RW, oMEM_MASK,
    input  oMEM_CTRL, oMEM_ADDR, oMEM_DATA
  );
endinterface

// File: rtl/l1_data_mem_req_fifo.sv
// Request FIFO with flush; flush beats push/pop.
// Full FIFO still accepts a push paired with a pop.
module l1_data_mem_req_fifo
  import l1_data_mem_responder_pkg::*;
#(
  parameter int P_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  req_t                     din,
  output req_t                     dout,
  output logic [$clog2(P_DEPTH):0] count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(P_DEPTH);
  localparam logic [AW:0] DEPTH = P_DEPTH[AW:0];

  req_t          mem_q [P_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = count_q == DEPTH;
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case (1'b1)
        do_push && !do_pop: count_d = count_q + 1'b1;
        do_pop && !do_push: count_d = count_q - 1'b1;
        default:            count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/l1_data_mem_responder.sv
// Queues L1 data requests and runs them one at a
// time against memory, returning responses in order.
module l1_data_mem_responder
  import l1_data_mem_responder_pkg::*;
#(
  parameter int P_DEPTH = 4
) (
  input logic                    iCLOCK,
  input logic                    iRESET_SYNC,
  l1_data_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic        rw_q, rw_d;
  logic [63:0] rdata_q, rdata_d;
  logic [23:0] flags_q, flags_d;

  req_t din, head;
  logic full, empty, push, pop;
  logic issue, more;
  logic [$clog2(P_DEPTH):0] count_unused;

  always_comb begin
    din.order  = order_e'(bus.iDATA_ORDER);
    din.mask   = bus.iDATA_MASK;
    din.rw     = rw_e'(bus.iDATA_RW);
    din.tid    = bus.iDATA_TID;
    din.mmumod = bus.iDATA_MMUMOD;
    din.mmups  = bus.iDATA_MMUPS;
    din.pdt    = bus.iDATA_PDT;
    din.addr   = bus.iDATA_ADDR;
    din.data   = bus.iDATA_DATA;
  end

  assign issue = state_q == S_ISSUE;
  assign push  = bus.iDATA_REQ && !full;
  assign pop   = issue && !bus.iMEM_BUSY;
  // FIFO will hold something after this edge
  assign more  = !bus.iREMOVE && (push || !empty);

  l1_data_mem_req_fifo #(.P_DEPTH(P_DEPTH)) u_fifo (
    .clk   (iCLOCK),
    .rst   (iRESET_SYNC),
    .push  (push),
    .pop   (pop),
    .flush (bus.iREMOVE),
    .din   (din),
    .dout  (head),
    .count (count_unused),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
    flags_d = flags_q;
    unique case (state_q)
      S_IDLE: if (more) state_d = S_ISSUE;
      S_ISSUE: begin
        if (pop) begin
          state_d = S_WAIT;
          rw_d    = head.rw == RW_WRITE;
          drop_d  = bus.iREMOVE;
        end else if (bus.iREMOVE) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.iREMOVE) drop_d = 1'b1;
        if (bus.iMEM_VALID) begin
          if (drop_q || bus.iREMOVE) begin
            // removed transaction: finish silently
            drop_d  = 1'b0;
            state_d = more ? S_ISSUE : S_IDLE;
          end else begin
            state_d = S_RESP;
            rdata_d = rw_q ? 64'h0 : bus.iMEM_DATA;
            flags_d = bus.iMEM_MMU_FLAGS;
          end
        end
      end
      S_RESP: state_d = more ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      flags_q <= flags_d;
    end
  end

  assign bus.oDATA_LOCK      = full;
  assign bus.oDATA_VALID     = state_q == S_RESP;
  assign bus.oDATA_DATA      = rdata_q;
  assign bus.oDATA_MMU_FLAGS = flags_q;

  assign bus.oMEM_REQ  = issue;
  assign bus.oMEM_RW   = issue && head.rw == RW_WRITE;
  assign bus.oMEM_MASK = issue ? lane_mask(head) : '0;
  assign bus.oMEM_DATA = issue ? lane_data(head) : '0;
  assign bus.oMEM_ADDR = issue ? {head.addr[31:3], 3'b000}
                               : '0;
  assign bus.oMEM_CTRL = issue ? {head.tid, head.mmumod,
                                  head.mmups, head.pdt}
                               : '0;

endmodule

// File: tb/tb_l1_data_mem_responder.sv
// Scoreboard bench: request/memory model feeds expected
// responses; a negedge monitor checks every cycle.
module tb_l1_data_mem_responder;
  localparam int P_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_data_mem_responder_if bus();

  l1_data_mem_responder #(.P_DEPTH(P_DEPTH)) dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .bus         (bus)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic [13:0] tid;
    logic [1:0]  mod;
    logic [2:0]  ps;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
  } req_s;

  typedef struct {
    logic [63:0] data;
    logic [23:0] flags;
    int          cyc;
  } rsp_s;

  req_s reqq[$];
  rsp_s rspq[$];
  req_s cur;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit req_on, remove_on, busy_on, rst_on;
  bit spur_en, force_valid, fixed_en;
  bit last_acc, inflight, drop, in_rw;
  int mdelay, delay_fix;
  logic [63:0] fixed_data;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [255:0] act,
                     logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  function automatic req_s rand_req();
    req_s r;
    r.rw    = 1'($urandom_range(0, 1));
    r.order = 2'($urandom_range(0, 2));
    r.mask  = 4'($urandom);
    r.tid   = 14'($urandom);
    r.mod   = 2'($urandom);
    r.ps    = 3'($urandom);
    r.pdt   = $urandom;
    r.addr  = $urandom;
    r.data  = $urandom;
    return r;
  endfunction

  function automatic req_s mk(logic rw, logic [31:0] a,
                              logic [3:0] m,
                              logic [31:0] d);
    req_s r;
    r = rand_req();
    r.rw = rw; r.addr = a; r.mask = m; r.data = d;
    return r;
  endfunction

  // one clock: drive at negedge, judge the coming edge
  task automatic step();
    int   size0;
    bit   mv, xfer;
    req_s f;
    logic [7:0]  em;
    logic [63:0] ed;
    rst              = rst_on;
    bus.iDATA_REQ    = req_on;
    bus.iDATA_ORDER  = cur.order;
    bus.iDATA_MASK   = cur.mask;
    bus.iDATA_RW     = cur.rw;
    bus.iDATA_TID    = cur.tid;
    bus.iDATA_MMUMOD = cur.mod;
    bus.iDATA_MMUPS  = cur.ps;
    bus.iDATA_PDT    = cur.pdt;
    bus.iDATA_ADDR   = cur.addr;
    bus.iDATA_DATA   = cur.data;
    bus.iREMOVE      = remove_on;
    bus.iMEM_BUSY    = busy_on || rst_on;
    mv = 1'b0;
    if (inflight && !rst_on) begin
      if (mdelay == 0) mv = 1'b1;
      else mdelay--;
    end else if (!inflight) begin
      mv = force_valid ||
           (spur_en && $urandom_range(0, 15) == 0);
    end
    bus.iMEM_VALID     = mv;
    bus.iMEM_DATA      = fixed_en ? fixed_data
                                  : {$urandom, $urandom};
    bus.iMEM_MMU_FLAGS = 24'($urandom);
    #1;
    size0 = reqq.size();
    chk("lock", bus.oDATA_LOCK, size0 == P_DEPTH);
    if (size0 == 0) chk("req_when_empty", bus.oMEM_REQ, 0);
    last_acc = 1'b0;
    if (rst_on) begin
      reqq.delete();
      inflight = 1'b0;
    end else begin
      if (mv && inflight) begin
        if (!(drop || remove_on))
          rspq.push_back('{in_rw ? 64'h0 : bus.iMEM_DATA,
                           bus.iMEM_MMU_FLAGS, cyc + 1});
        inflight = 1'b0;
      end
      xfer = bus.oMEM_REQ && !bus.iMEM_BUSY;
      if (xfer && size0 > 0) begin
        f  = reqq.pop_front();
        em = f.rw ? (8'(f.mask) << (f.addr[2] ? 4 : 0))
                  : 8'hFF;
        ed = f.rw ? (64'(f.data) << (f.addr[2] ? 32 : 0))
                  : 64'h0;
        chk("mem_addr", bus.oMEM_ADDR, f.addr & ~32'h7);
        chk("mem_rw", bus.oMEM_RW, f.rw);
        chk("mem_mask", bus.oMEM_MASK, em);
        chk("mem_data", bus.oMEM_DATA, ed);
        chk("mem_ctrl", bus.oMEM_CTRL,
            {f.tid, f.mod, f.ps, f.pdt});
        inflight = 1'b1;
        drop     = remove_on;
        in_rw    = f.rw;
        mdelay   = delay_fix >= 0 ? delay_fix
                                  : $urandom_range(0, 3);
      end
      if (remove_on) begin
        reqq.delete();
        if (inflight) drop = 1'b1;
      end
      if (req_on && !remove_on && size0 < P_DEPTH) begin
        reqq.push_back(cur);
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic push_one(req_s r);
    cur = r; req_on = 1'b1;
    for (int g = 0; g < 20; g++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) chk("push_timeout", 0, 1);
    req_on = 1'b0;
  endtask

  task automatic drain();
    int g;
    req_on = 0; remove_on = 0; busy_on = 0; rst_on = 0;
    g = 0;
    while ((reqq.size() > 0 || inflight || rspq.size() > 0)
           && g < 200) begin
      step(); g++;
    end
    chk("drain_timeout", g < 200, 1);
  endtask

  task automatic chk_all_zero(string name);
    chk(name, {bus.oDATA_LOCK, bus.oDATA_VALID,
               bus.oDATA_DATA, bus.oDATA_MMU_FLAGS,
               bus.oMEM_REQ, bus.oMEM_RW, bus.oMEM_MASK,
               bus.oMEM_CTRL, bus.oMEM_ADDR, bus.oMEM_DATA},
        0);
  endtask

  always @(negedge clk) begin : monitor
    rsp_s e;
    if (rspq.size() > 0 && rspq[0].cyc == cyc) begin
      e = rspq.pop_front();
      chk("rsp_valid", bus.oDATA_VALID, 1);
      chk("rsp_data", bus.oDATA_DATA, e.data);
      chk("rsp_flags", bus.oDATA_MMU_FLAGS, e.flags);
    end else begin
      chk("no_extra_valid", bus.oDATA_VALID, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = rand_req();
    req_on = 0; remove_on = 0; busy_on = 0; rst_on = 1;
    spur_en = 0; force_valid = 0; fixed_en = 0;
    inflight = 0; drop = 0; in_rw = 0; delay_fix = 0;
    mdelay = 0; fixed_data = '0;
    bus.iDATA_REQ = 0; bus.iREMOVE = 0; bus.iMEM_BUSY = 1;
    bus.iMEM_VALID = 0; bus.iMEM_DATA = '0;
    bus.iMEM_MMU_FLAGS = '0;
    bus.iDATA_ORDER = '0; bus.iDATA_MASK = '0;
    bus.iDATA_RW = 0; bus.iDATA_TID = '0;
    bus.iDATA_MMUMOD = '0; bus.iDATA_MMUPS = '0;
    bus.iDATA_PDT = '0; bus.iDATA_ADDR = '0;
    bus.iDATA_DATA = '0;
    @(negedge clk);
    step(); step();
    #1 chk_all_zero("reset_outputs");
    rst_on = 0;

    // read, zero busy
    fixed_en = 1; fixed_data = 64'h1111_2222_3333_4444;
    cur = mk(1'b0, 32'h0000_1004, 4'hF, 32'h0);
    req_on = 1; step(); req_on = 0;
    #1;
    chk("read_req_next_cycle", bus.oMEM_REQ, 1);
    chk("read_addr", bus.oMEM_ADDR, 32'h0000_1000);
    chk("read_mask", bus.oMEM_MASK, 8'hFF);
    drain();

    // write to upper lane
    cur = mk(1'b1, 32'h0000_0024, 4'h3, 32'hAABB_CCDD);
    req_on = 1; step(); req_on = 0;
    #1;
    chk("write_mask", bus.oMEM_MASK, 8'h30);
    chk("write_data", bus.oMEM_DATA,
        64'hAABB_CCDD_0000_0000);
    drain();
    fixed_en = 0;

    // fill under busy, fifth held, order kept
    busy_on = 1;
    for (int i = 0; i < 4; i++) begin
      push_one(rand_req());
      busy_on = 1;
    end
    #1 chk("lock_after_fourth", bus.oDATA_LOCK, 1);
    cur = rand_req(); req_on = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1 chk("fifth_held", bus.oDATA_LOCK, 1);
    end
    busy_on = 0;
    for (int g = 0; g < 20; g++) begin
      step();
      if (last_acc) break;
    end
    chk("fifth_accepted", last_acc, 1);
    drain();

    // remove while waiting with two queued
    delay_fix = 8;
    cur = rand_req(); req_on = 1; step();
    cur = rand_req(); step();
    cur = rand_req(); step();
    req_on = 0; remove_on = 1; step(); remove_on = 0;
    #1 chk("remove_empty", bus.oDATA_LOCK, 0);
    repeat (12) step();
    #1 chk("remove_idle", bus.oMEM_REQ, 0);

    // reset while waiting, late completion ignored
    delay_fix = 4;
    cur = rand_req(); req_on = 1; step(); req_on = 0;
    step(); step();
    rst_on = 1; step(); rst_on = 0;
    force_valid = 1; step(); force_valid = 0;
    step();
    #1 chk_all_zero("reset_mid_txn");
    delay_fix = -1;

    // random traffic
    spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!req_on || last_acc) begin
        cur = rand_req();
        req_on = $urandom_range(0, 9) < 6;
      end
      remove_on = $urandom_range(0, 63) == 0;
      busy_on   = $urandom_range(0, 3) == 0;
      rst_on    = $urandom_range(0, 499) == 0;
      step();
    end
    spur_en = 0;
    drain();
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
